prl_tx_multi_sop: RTL and testbench

//  Parametrised USB-PD Protocol Layer transmit engine. Successor to the single-channel Tx FSM.

---
 rtl/prl_tx_multi_sop_if.sv | 50 +++++
 rtl/prl_tx_multi_sop.sv | 188 ++++++++++++++++++
 tb/tb_prl_tx_multi_sop.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prl_tx_multi_sop_if.sv
// USB-PD Protocol Layer transmit bus: TCPC TRANSMIT request, PHY frame handshake,
// GoodCRC / collision / Hard Reset inputs, alert pulses and a state debug view.
//
// PHY handshake: the frame is transferred in a cycle where phy_tx_valid && phy_tx_ready.
// While valid is high without ready, valid, data, bytes and sop are held stable, and
// valid never depends combinationally on ready.
interface prl_tx_multi_sop_if #(
  parameter int MAX_DO = 7
);
  logic                    transmit_req;
  logic [2:0]              transmit_sop;
  logic [7:0]              transmit_byte_count;
  logic [15:0]             transmit_header;
  logic [32*MAX_DO-1:0]    transmit_data_objects;

  logic                    phy_tx_valid;
  logic                    phy_tx_ready;
  logic [16+32*MAX_DO-1:0] phy_tx_data;
  logic [7:0]              phy_tx_bytes;
  logic [2:0]              phy_tx_sop;
  logic                    phy_tx_done;

  logic                    goodcrc_valid;
  logic [2:0]              goodcrc_msgid;
  logic [2:0]              goodcrc_sop;
  logic                    rx_msg_discard;
  logic                    hard_reset;

  logic                    alert_tx_success;
  logic                    alert_tx_failed;
  logic                    alert_tx_discarded;
  logic                    busy;
  logic [3:0]              dbg_state;

  modport slave (
    input  transmit_req, transmit_sop, transmit_byte_count, transmit_header,
           transmit_data_objects, phy_tx_ready, phy_tx_done, goodcrc_valid,
           goodcrc_msgid, goodcrc_sop, rx_msg_discard, hard_reset,
    output phy_tx_valid, phy_tx_data, phy_tx_bytes, phy_tx_sop,
           alert_tx_success, alert_tx_failed, alert_tx_discarded, busy, dbg_state
  );

  modport master (
    output transmit_req, transmit_sop, transmit_byte_count, transmit_header,
           transmit_data_objects, phy_tx_ready, phy_tx_done, goodcrc_valid,
           goodcrc_msgid, goodcrc_sop, rx_msg_discard, hard_reset,
    input  phy_tx_valid, phy_tx_data, phy_tx_bytes, phy_tx_sop,
           alert_tx_success, alert_tx_failed, alert_tx_discarded, busy, dbg_state
  );
endinterface

// File: rtl/prl_tx_multi_sop.sv
// USB-PD Protocol Layer transmit engine: per-SOP MessageIDs, PHY valid/ready handoff,
// GoodCRC timer with retries, collision discard and Hard Reset abort.
module prl_tx_multi_sop #(
  parameter int MAX_DO      = 7,
  parameter int N_SOP       = 3,
  parameter int N_RETRY     = 2,
  parameter int CRC_TIMEOUT = 8
) (
  input logic               CLK,
  input logic               RESET,
  prl_tx_multi_sop_if.slave bus
);
  localparam int          DW        = 32 * MAX_DO;
  localparam int          FW        = 16 + DW;
  localparam int          RW        = (N_RETRY < 1) ? 1 : $clog2(N_RETRY + 1);
  localparam logic [7:0]  TMO_LAST  = 8'(CRC_TIMEOUT - 1);
  localparam logic [7:0]  MAX_BYTES = 8'(2 + 4 * MAX_DO);
  localparam logic [2:0]  N_SOP_L   = 3'(N_SOP);
  localparam logic [15:0] ID_MASK   = 16'h0E00;
  localparam logic [RW-1:0] RETRY_LAST = RW'(N_RETRY);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_CONSTRUCT   = 4'd1,
    S_SEND        = 4'd2,
    S_WAIT_DONE   = 4'd3,
    S_WAIT_CRC    = 4'd4,
    S_CHECK_RETRY = 4'd5,
    S_SUCCESS     = 4'd6,
    S_FAIL        = 4'd7,
    S_DISCARD     = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    sop_q, sop_d;
  logic [7:0]    bytes_q, bytes_d;
  logic [15:0]   hdr_q, hdr_d;
  logic [DW-1:0] dos_q, dos_d;
  logic          legal_q, legal_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    timer_q, timer_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [7:0]    phy_bytes_q, phy_bytes_d;
  logic [2:0]    phy_sop_q, phy_sop_d;
  // Eight slots so a 3-bit SOP indexes without a range check; only 0..N_SOP-1 ever change.
  logic [2:0]    msgid_q [8];
  logic [2:0]    msgid_d [8];

  logic          req_legal;
  logic          crc_match;

  assign req_legal = (bus.transmit_sop < N_SOP_L)
                  && !bus.transmit_byte_count[0]
                  && (bus.transmit_byte_count >= 8'd2)
                  && (bus.transmit_byte_count <= MAX_BYTES);

  assign crc_match = bus.goodcrc_valid
                  && (bus.goodcrc_sop == sop_q)
                  && (bus.goodcrc_msgid == msgid_q[sop_q]);

  always_comb begin
    state_d     = state_q;
    sop_d       = sop_q;
    bytes_d     = bytes_q;
    hdr_d       = hdr_q;
    dos_d       = dos_q;
    legal_d     = legal_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    frame_d     = frame_q;
    phy_bytes_d = phy_bytes_q;
    phy_sop_d   = phy_sop_q;
    msgid_d     = msgid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.transmit_req) begin
          sop_d   = bus.transmit_sop;
          bytes_d = bus.transmit_byte_count;
          hdr_d   = bus.transmit_header;
          dos_d   = bus.transmit_data_objects;
          legal_d = req_legal;
          retry_d = '0;
          state_d = S_CONSTRUCT;
        end
      end

      // An illegal request still passes through here so its FAIL pulse lands two
      // cycles after REQ, the same slot where a legal frame raises PHY valid.
      S_CONSTRUCT: begin
        if (!legal_q) begin
          state_d = S_FAIL;
        end else if (bus.rx_msg_discard) begin
          state_d = S_DISCARD;
        end else begin
          frame_d     = {(hdr_q & ~ID_MASK) | {4'b0, msgid_q[sop_q], 9'b0}, dos_q};
          phy_bytes_d = bytes_q;
          phy_sop_d   = sop_q;
          state_d     = S_SEND;
        end
      end

      // An accepted handshake takes precedence over a collision in the same cycle.
      S_SEND: begin
        if (bus.phy_tx_ready) begin
          state_d = S_WAIT_DONE;
        end else if (bus.rx_msg_discard) begin
          state_d = S_DISCARD;
        end
      end

      S_WAIT_DONE: begin
        if (bus.phy_tx_done) begin
          timer_d = '0;
          state_d = S_WAIT_CRC;
        end
      end

      S_WAIT_CRC: begin
        if (crc_match) begin
          state_d = S_SUCCESS;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_CHECK_RETRY;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_CHECK_RETRY: begin
        if (retry_q == RETRY_LAST) begin
          state_d = S_FAIL;
        end else begin
          retry_d = retry_q + RW'(1);
          state_d = S_CONSTRUCT;
        end
      end

      S_SUCCESS: begin
        msgid_d[sop_q] = msgid_q[sop_q] + 3'd1;
        state_d        = S_IDLE;
      end

      S_FAIL:    state_d = S_IDLE;
      S_DISCARD: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET || bus.hard_reset) begin
      state_q     <= S_IDLE;
      sop_q       <= '0;
      bytes_q     <= '0;
      hdr_q       <= '0;
      dos_q       <= '0;
      legal_q     <= 1'b0;
      retry_q     <= '0;
      timer_q     <= '0;
      frame_q     <= '0;
      phy_bytes_q <= '0;
      phy_sop_q   <= '0;
      for (int i = 0; i < 8; i++) msgid_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sop_q       <= sop_d;
      bytes_q     <= bytes_d;
      hdr_q       <= hdr_d;
      dos_q       <= dos_d;
      legal_q     <= legal_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      frame_q     <= frame_d;
      phy_bytes_q <= phy_bytes_d;
      phy_sop_q   <= phy_sop_d;
      msgid_q     <= msgid_d;
    end
  end

  assign bus.phy_tx_valid       = (state_q == S_SEND);
  assign bus.phy_tx_data        = frame_q;
  assign bus.phy_tx_bytes       = phy_bytes_q;
  assign bus.phy_tx_sop         = phy_sop_q;
  assign bus.alert_tx_success   = (state_q == S_SUCCESS);
  assign bus.alert_tx_failed    = (state_q == S_FAIL);
  assign bus.alert_tx_discarded = (state_q == S_DISCARD);
  assign bus.busy               = (state_q != S_IDLE);
  assign bus.dbg_state          = state_q;
endmodule

// File: tb/tb_prl_tx_multi_sop.sv
// Bench for prl_tx_multi_sop: legality table, hand-built multi-cycle sequences and
// randomized transactions checked against a transaction-level MessageID model.
module tb_prl_tx_multi_sop;
  localparam int MAX_DO      = 7;
  localparam int N_SOP       = 3;
  localparam int N_RETRY     = 2;
  localparam int CRC_TIMEOUT = 8;
  localparam int DW          = 32 * MAX_DO;
  localparam int FW          = 16 + DW;

  typedef struct {
    logic [2:0] sop;
    logic [7:0] cnt;
    bit         legal;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  prl_tx_multi_sop_if #(.MAX_DO(MAX_DO)) bus ();

  prl_tx_multi_sop #(
    .MAX_DO(MAX_DO), .N_SOP(N_SOP), .N_RETRY(N_RETRY), .CRC_TIMEOUT(CRC_TIMEOUT)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int alerts_seen = 0;
  int alerts_exp  = 0;

  logic [FW-1:0] exp_q[$];
  logic [2:0]    model_id [8];
  logic [15:0]   cur_hdr;
  logic [DW-1:0] cur_dos;
  logic [FW-1:0] cur_frame;
  int            plan [N_RETRY+1];
  vec_t          tbl [10];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [2:0] sop, input logic [7:0] cnt);
    int c;
    c = int'(cnt);
    return (int'(sop) < N_SOP) && (c % 2 == 0) && (c >= 2) && (c <= 2 + 4 * MAX_DO);
  endfunction

  function automatic logic [FW-1:0] make_frame(input logic [15:0] h, input logic [2:0] id,
                                               input logic [DW-1:0] d);
    logic [15:0] hh;
    hh = h;
    hh[11:9] = id;
    return {hh, d};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [FW-1:0] e;
    if (!rst && bus.phy_tx_valid && bus.phy_tx_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL frame_unexpected: got %0h required none", bus.phy_tx_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.phy_tx_data === e) n_pass++;
        else $display("FAIL frame: got %0h required %0h", bus.phy_tx_data, e);
      end
    end
    alerts_seen += int'(bus.alert_tx_success) + int'(bus.alert_tx_failed)
                 + int'(bus.alert_tx_discarded);
  end

  // ---------------- driver tasks ----------------
  task automatic set_plan(input int a, input int b, input int c);
    plan[0] = a;
    plan[1] = b;
    plan[2] = c;
  endtask

  // Leaves the bench in the cycle two after REQ.
  task automatic send_req(input logic [2:0] sop, input logic [7:0] cnt);
    cur_hdr = 16'($urandom);
    for (int i = 0; i < MAX_DO; i++) cur_dos[i*32 +: 32] = $urandom;
    bus.transmit_req          = 1'b1;
    bus.transmit_sop          = sop;
    bus.transmit_byte_count   = cnt;
    bus.transmit_header       = cur_hdr;
    bus.transmit_data_objects = cur_dos;
    step();
    bus.transmit_req          = 1'b0;
    bus.transmit_header       = 16'($urandom);
    bus.transmit_data_objects = '0;
    check("valid_low_c1", bus.phy_tx_valid, 0);
    check("busy_c1", bus.busy, 1);
    step();
  endtask

  task automatic run_illegal(input logic [2:0] sop, input logic [7:0] cnt);
    send_req(sop, cnt);
    check("fail_pulse_illegal", bus.alert_tx_failed, 1);
    check("valid_low_illegal", bus.phy_tx_valid, 0);
    alerts_exp++;
    step();
    check("idle_after_illegal", bus.busy, 0);
    check("valid_low_after_illegal", bus.phy_tx_valid, 0);
  endtask

  task automatic drive_crc(input logic [2:0] sop, input logic [2:0] id);
    bus.goodcrc_valid = 1'b1;
    bus.goodcrc_sop   = sop;
    bus.goodcrc_msgid = id;
    step();
    bus.goodcrc_valid = 1'b0;
  endtask

  // plan[a] = cycle after PHY_TX_DONE carrying the matching GoodCRC (0 = none).
  task automatic run_legal(input logic [2:0] sop, input logic [7:0] cnt, input int ready_wait,
                           input bit wrong_first, input bit disc_early, input bit disc_late);
    int rel;
    send_req(sop, cnt);
    for (int a = 0; a <= N_RETRY; a++) begin
      cur_frame = make_frame(cur_hdr, model_id[sop], cur_dos);
      check("valid_rise", bus.phy_tx_valid, 1);
      check("tx_bytes", bus.phy_tx_bytes, cnt);
      check("tx_sop", bus.phy_tx_sop, sop);
      if (disc_early) begin
        bus.rx_msg_discard = 1'b1;
        step();
        bus.rx_msg_discard = 1'b0;
        check("discarded_pulse", bus.alert_tx_discarded, 1);
        check("valid_after_discard", bus.phy_tx_valid, 0);
        alerts_exp++;
        step();
        check("idle_after_discard", bus.busy, 0);
        return;
      end
      exp_q.push_back(cur_frame);
      for (int w = 0; w < ready_wait; w++) begin
        step();
        check("valid_hold", bus.phy_tx_valid, 1);
        check("frame_hold", bus.phy_tx_data, cur_frame);
      end
      bus.phy_tx_ready = 1'b1;
      step();
      bus.phy_tx_ready = 1'b0;
      check("valid_drop", bus.phy_tx_valid, 0);
      bus.phy_tx_done = 1'b1;
      step();
      bus.phy_tx_done = 1'b0;
      rel = 1;
      if (wrong_first) begin
        drive_crc(sop, model_id[sop] + 3'd5);
        drive_crc(3'((int'(sop) + 1) % N_SOP), model_id[sop]);
        rel += 2;
      end
      if (disc_late) begin
        bus.rx_msg_discard = 1'b1;
        step();
        bus.rx_msg_discard = 1'b0;
        rel++;
      end
      if (plan[a] > 0) begin
        while (rel < plan[a]) begin step(); rel++; end
        drive_crc(sop, model_id[sop]);
        check("success_pulse", bus.alert_tx_success, 1);
        check("no_fail_on_success", bus.alert_tx_failed, 0);
        alerts_exp++;
        model_id[sop] = model_id[sop] + 3'd1;
        step();
        check("idle_after_success", bus.busy, 0);
        return;
      end
      // Timer runs CRC_TIMEOUT cycles, one retry-decision cycle, then FAIL or CONSTRUCT.
      while (rel < CRC_TIMEOUT + 2) begin
        check("no_alert_waiting", bus.alert_tx_failed | bus.alert_tx_success, 0);
        step();
        rel++;
      end
      if (a == N_RETRY) begin
        check("failed_pulse", bus.alert_tx_failed, 1);
        alerts_exp++;
        step();
        check("idle_after_fail", bus.busy, 0);
        return;
      end
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.transmit_req = 1'b0;  bus.transmit_sop = '0;  bus.transmit_byte_count = '0;
    bus.transmit_header = '0; bus.transmit_data_objects = '0;
    bus.phy_tx_ready = 1'b0;  bus.phy_tx_done = 1'b0;
    bus.goodcrc_valid = 1'b0; bus.goodcrc_msgid = '0; bus.goodcrc_sop = '0;
    bus.rx_msg_discard = 1'b0; bus.hard_reset = 1'b0;
    for (int i = 0; i < 8; i++) model_id[i] = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_valid", bus.phy_tx_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_alerts", {bus.alert_tx_success, bus.alert_tx_failed, bus.alert_tx_discarded}, 0);
    check("rst_data", {bus.phy_tx_data, bus.phy_tx_bytes, bus.phy_tx_sop}, 0);

    // Legality table: legal rows complete with GoodCRC one cycle after DONE.
    tbl[0] = '{3'd0, 8'd6,  1'b1};  tbl[1] = '{3'd2, 8'd2,  1'b1};
    tbl[2] = '{3'd1, 8'd30, 1'b1};  tbl[3] = '{3'd3, 8'd6,  1'b0};
    tbl[4] = '{3'd6, 8'd6,  1'b0};  tbl[5] = '{3'd0, 8'd3,  1'b0};
    tbl[6] = '{3'd0, 8'd0,  1'b0};  tbl[7] = '{3'd0, 8'd32, 1'b0};
    tbl[8] = '{3'd7, 8'd4,  1'b0};  tbl[9] = '{3'd2, 8'd28, 1'b1};
    for (int i = 0; i < 10; i++) begin
      set_plan(1, 0, 0);
      if (tbl[i].legal) run_legal(tbl[i].sop, tbl[i].cnt, 0, 1'b0, 1'b0, 1'b0);
      else run_illegal(tbl[i].sop, tbl[i].cnt);
    end

    // GoodCRC three cycles after DONE.
    set_plan(3, 0, 0);  run_legal(3'd0, 8'd6, 0, 1'b0, 1'b0, 1'b0);
    // No GoodCRC at all: three identical attempts then FAIL.
    set_plan(0, 0, 0);  run_legal(3'd0, 8'd10, 1, 1'b0, 1'b0, 1'b0);
    // First attempt times out, second succeeds.
    set_plan(0, 2, 0);  run_legal(3'd2, 8'd8, 0, 1'b0, 1'b0, 1'b0);
    // Wrong id and wrong SOP ignored, then match.
    set_plan(5, 0, 0);  run_legal(3'd1, 8'd4, 2, 1'b1, 1'b0, 1'b0);
    // GoodCRC on the last timer cycle wins over timeout.
    set_plan(CRC_TIMEOUT, 0, 0); run_legal(3'd0, 8'd2, 0, 1'b0, 1'b0, 1'b0);
    // MessageID wrap on SOP' while SOP keeps its own counter.
    for (int i = 0; i < 9; i++) begin
      set_plan(1, 0, 0);
      run_legal(3'd1, 8'd6, 0, 1'b0, 1'b0, 1'b0);
    end
    set_plan(2, 0, 0);  run_legal(3'd0, 8'd6, 0, 1'b0, 1'b0, 1'b0);
    // Collision before handshake discards; collision in WAIT_CRC ignored.
    set_plan(1, 0, 0);  run_legal(3'd0, 8'd6, 0, 1'b0, 1'b1, 1'b0);
    set_plan(4, 0, 0);  run_legal(3'd2, 8'd6, 0, 1'b0, 1'b0, 1'b1);

    // REQ during an alert cycle is ignored.
    send_req(3'd5, 8'd4);
    check("fail_pulse_before_req", bus.alert_tx_failed, 1);
    alerts_exp++;
    bus.transmit_req = 1'b1;  bus.transmit_sop = 3'd0;  bus.transmit_byte_count = 8'd4;
    step();
    bus.transmit_req = 1'b0;
    check("req_on_alert_ignored", bus.busy, 0);
    step();
    check("req_on_alert_no_valid", bus.phy_tx_valid, 0);

    // Hard Reset coincident with a matching GoodCRC.
    send_req(3'd1, 8'd6);
    exp_q.push_back(make_frame(cur_hdr, model_id[1], cur_dos));
    check("hr_valid_rise", bus.phy_tx_valid, 1);
    bus.phy_tx_ready = 1'b1;  step();  bus.phy_tx_ready = 1'b0;
    bus.phy_tx_done  = 1'b1;  step();  bus.phy_tx_done  = 1'b0;
    step();  step();
    bus.hard_reset = 1'b1;
    drive_crc(3'd1, model_id[1]);
    bus.hard_reset = 1'b0;
    for (int i = 0; i < 8; i++) model_id[i] = '0;
    check("hr_no_success", bus.alert_tx_success, 0);
    check("hr_idle", bus.busy, 0);
    check("hr_outputs", {bus.phy_tx_valid, bus.phy_tx_data, bus.phy_tx_bytes}, 0);
    step();
    check("hr_no_late_alert", bus.alert_tx_success, 0);
    for (int s = 0; s < N_SOP; s++) begin
      set_plan(1, 0, 0);
      run_legal(3'(s), 8'd2, 0, 1'b0, 1'b0, 1'b0);
    end

    // Randomized transactions against the MessageID model.
    for (int t = 0; t < 40; t++) begin
      logic [2:0] sop;
      logic [7:0] cnt;
      bit wf, dl, de;
      int kmin;
      sop = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, N_SOP - 1)) : 3'($urandom_range(0, 7));
      cnt = ($urandom_range(0, 7) < 6) ? 8'(2 * $urandom_range(1, 1 + 2 * MAX_DO))
                                       : 8'($urandom_range(0, 40));
      if (!is_legal(sop, cnt)) begin
        run_illegal(sop, cnt);
      end else begin
        wf = ($urandom % 4 == 0);
        dl = ($urandom % 4 == 0);
        de = ($urandom % 8 == 0);
        kmin = 1 + (wf ? 2 : 0) + (dl ? 1 : 0);
        for (int a = 0; a <= N_RETRY; a++)
          plan[a] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(kmin, CRC_TIMEOUT));
        run_legal(sop, cnt, int'($urandom_range(0, 3)), wf, de, dl);
      end
    end

    step();
    check("alert_count", alerts_seen, alerts_exp);
    check("frames_all_sent", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
